// File: rtl/fir_filter_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_filter_mc
// Description : Multi-channel, time-multiplexed FIR filter. One MAC per
//               cycle, one tap per cycle, newest sample first. Each channel
//               keeps its own circular sample history and write pointer;
//               the coefficient set is shared. The result is rounded
//               half-up, arithmetically shifted and saturated to DataBits.
//               A bypass mode returns the accepted sample unchanged while
//               still recording it in the history.
// Ports       : clk_i, rst_ni        clock, asynchronous active-low reset
//               data_i, ch_i,        input sample, its channel,
//               bypass_i             pass-through request
//               in_valid_i/in_ready_o   input handshake (ready only in IDLE)
//               data_o, ch_o         filtered sample and its channel
//               out_valid_o/out_ready_i output handshake
//               coeff_we_i, coeff_addr_i, coeff_i  coefficient write port
//               flush_i              clears all histories (IDLE only)
//               busy_o               state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module fir_filter_mc #(
    parameter int Taps      = 8,
    parameter int DataBits  = 10,
    parameter int CoeffBits = 10,
    parameter int Channels  = 4,
    parameter int Shift     = 8
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic [DataBits-1:0]                               data_i,
    input  logic [((Channels > 1) ? $clog2(Channels) : 1)-1:0] ch_i,
    input  logic                                              bypass_i,
    input  logic                                              in_valid_i,
    output logic                                              in_ready_o,
    output logic [DataBits-1:0]                               data_o,
    output logic [((Channels > 1) ? $clog2(Channels) : 1)-1:0] ch_o,
    output logic                                              out_valid_o,
    input  logic                                              out_ready_i,
    input  logic                                              coeff_we_i,
    input  logic [$clog2(Taps)-1:0]                           coeff_addr_i,
    input  logic [CoeffBits-1:0]                              coeff_i,
    input  logic                                              flush_i,
    output logic                                              busy_o
);

    localparam int CH_W   = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int TAP_W  = $clog2(Taps);
    localparam int PROD_W = DataBits + CoeffBits;
    localparam int ACC_W  = PROD_W + TAP_W;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(Taps - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // Rounding constant and saturation bounds, one bit wider than the
    // accumulator so adding the half-LSB can never wrap.
    localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'(64'sd1 <<< (Shift - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((64'sd1 <<< (DataBits - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                  state_q, state_d;
    logic                        in_ready_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [TAP_W-1:0]            tap_q;
    logic [TAP_W-1:0]            rd_idx_q;
    logic [CH_W-1:0]             ch_q;
    logic [DataBits-1:0]         data_q;
    logic [TAP_W-1:0]            ptr_q   [Channels];
    logic signed [DataBits-1:0]  hist_q  [Channels][Taps];
    logic signed [CoeffBits-1:0] coeff_q [Taps];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic w_ch_ok;
    logic w_addr_ok;
    logic w_accept;
    logic w_take;
    logic w_flush;
    logic w_coeff_we;

    // Range checks only bite when Channels/Taps are not powers of two.
    assign w_ch_ok    = (int'(ch_i) < Channels);
    assign w_addr_ok  = (int'(coeff_addr_i) < Taps);
    // in_ready_q is high exactly when IDLE (except the first cycle after
    // reset). A flush in the same cycle swallows the accept.
    assign w_accept   = in_valid_i && in_ready_q && !flush_i;
    assign w_take     = w_accept && w_ch_ok;
    assign w_flush    = flush_i && (state_q == S_IDLE);
    assign w_coeff_we = coeff_we_i && (state_q == S_IDLE) && w_addr_ok;

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    logic signed [DataBits-1:0]  w_samp;
    logic signed [CoeffBits-1:0] w_coef;
    logic signed [PROD_W-1:0]    w_samp_ext;
    logic signed [PROD_W-1:0]    w_coef_ext;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]     w_acc_sum;
    logic signed [ACC_W:0]       w_rnd;
    logic signed [ACC_W:0]       w_shr;
    logic [DataBits-1:0]         w_sat;

    assign w_samp     = hist_q[ch_q][rd_idx_q];
    assign w_coef     = coeff_q[tap_q];
    // Operands widened to the full product width before multiplying so the
    // product is not truncated to the operand width.
    assign w_samp_ext = {{CoeffBits{w_samp[DataBits-1]}}, w_samp};
    assign w_coef_ext = {{DataBits{w_coef[CoeffBits-1]}}, w_coef};
    assign w_prod     = w_samp_ext * w_coef_ext;
    assign w_acc_sum  = acc_q + {{TAP_W{w_prod[PROD_W-1]}}, w_prod};
    assign w_rnd      = {w_acc_sum[ACC_W-1], w_acc_sum} + RND;
    assign w_shr      = w_rnd >>> Shift;

    always_comb begin
        w_sat = w_shr[DataBits-1:0];
        if (w_shr > SAT_MAX) begin
            w_sat = SAT_MAX[DataBits-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_sat = SAT_MIN[DataBits-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_take) begin
                    state_d = bypass_i ? S_OUT : S_RUN;
                end
            end
            S_RUN: begin
                // Result is registered on the last tap, so OUT follows it.
                if (tap_q == LAST_TAP) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, tap sequencing and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            tap_q    <= '0;
            rd_idx_q <= '0;
            ch_q     <= '0;
            data_q   <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (w_take) begin
                    ch_q     <= ch_i;
                    acc_q    <= '0;
                    tap_q    <= '0;
                    // The slot being written now holds the newest sample.
                    rd_idx_q <= ptr_q[ch_i];
                    if (bypass_i) begin
                        data_q <= data_i;
                    end
                end
            end else if (state_q == S_RUN) begin
                acc_q    <= w_acc_sum;
                tap_q    <= tap_q + 1'b1;
                rd_idx_q <= (rd_idx_q == '0) ? LAST_TAP : rd_idx_q - 1'b1;
                if (tap_q == LAST_TAP) begin
                    data_q <= w_sat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel sample histories and write pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < Channels; c++) begin
                ptr_q[c] <= '0;
                for (int t = 0; t < Taps; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
        end else if (w_flush) begin
            for (int c = 0; c < Channels; c++) begin
                ptr_q[c] <= '0;
                for (int t = 0; t < Taps; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
        end else if (w_take) begin
            hist_q[ch_i][ptr_q[ch_i]] <= data_i;
            ptr_q[ch_i] <= (ptr_q[ch_i] == LAST_TAP) ? '0 : ptr_q[ch_i] + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank; a write alongside an accept lands before RUN
    // reads it on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < Taps; t++) begin
                coeff_q[t] <= '0;
            end
        end else if (w_coeff_we) begin
            coeff_q[coeff_addr_i] <= coeff_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_IDLE);
    assign data_o      = data_q;
    assign ch_o        = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fir_filter_mc
// Description : Directed self-checking bench for fir_filter_mc with
//               Taps=4, DataBits=10, CoeffBits=10, Shift=8, Channels=2.
//               Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter_mc;

    localparam int TAPS = 4;
    localparam int DW   = 10;
    localparam int CW   = 10;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] data_i;
    logic [0:0]    ch_i;
    logic          bypass_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] data_o;
    logic [0:0]    ch_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          coeff_we_i;
    logic [1:0]    coeff_addr_i;
    logic [CW-1:0] coeff_i;
    logic          flush_i;
    logic          busy_o;

    int  total = 0;
    int  bad   = 0;
    time t_acc;
    time t_first;

    fir_filter_mc #(
        .Taps(TAPS), .DataBits(DW), .CoeffBits(CW), .Channels(2), .Shift(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .data_i(data_i), .ch_i(ch_i), .bypass_i(bypass_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_o(data_o), .ch_o(ch_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .coeff_we_i(coeff_we_i), .coeff_addr_i(coeff_addr_i), .coeff_i(coeff_i),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_coeffs(input int c0, input int c1, input int c2, input int c3);
        int c [4];
        int v;
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v            = c[i];
            coeff_we_i   = 1'b1;
            coeff_addr_i = 2'(i);
            coeff_i      = v[CW-1:0];
        end
        @(negedge clk);
        coeff_we_i = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    // Latency is the number of rising edges after the accept edge up to and
    // including the first edge at which out_valid_o is high.
    task automatic send(input string tag, input int ch, input int d, input bit byp,
                        input int exp_d, input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        ch_i        = ch[0:0];
        data_i      = d[DW-1:0];
        bypass_i    = byp;
        in_valid_i  = 1'b1;
        out_ready_i = (hold == 0);
        n = 0;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, in_ready_o, 1);
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid_i = 1'b0;
        bypass_i   = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_o && n < 20);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_data"}, $signed(data_o), exp_d);
        chk({tag, "_ch"}, ch_o, ch);
        if (hold > 0) begin
            // Offer another sample while stalled; it must not be taken.
            in_valid_i = 1'b1;
            data_i     = 10'sd77;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_bp_data"}, $signed(data_o), exp_d);
                chk({tag, "_bp_ch"}, ch_o, ch);
                chk({tag, "_bp_rdy"}, in_ready_o, 0);
                chk({tag, "_bp_valid"}, out_valid_o, 1);
            end
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        int seen;
        rst_ni       = 1'b0;
        data_i       = '0;
        ch_i         = '0;
        bypass_i     = 1'b0;
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b1;
        coeff_we_i   = 1'b0;
        coeff_addr_i = '0;
        coeff_i      = '0;
        flush_i      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", in_ready_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ch", ch_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", in_ready_o, 1);

        // Impulse response, with back-to-back throughput check
        write_coeffs(256, 128, -64, 0);
        do_flush();
        send("imp0", 0, 100, 1'b0, 100, 5, 0);
        t_first = t_acc;
        send("imp1", 0, 0, 1'b0, 50, 5, 0);
        chk("thruput_ns", int'(t_acc - t_first), 60);
        send("imp2", 0, 0, 1'b0, -25, 5, 0);
        send("imp3", 0, 0, 1'b0, 0, 5, 0);

        // Channel isolation
        write_coeffs(256, 256, 0, 0);
        do_flush();
        send("iso0", 0, 100, 1'b0, 100, 5, 0);
        send("iso1", 1, 200, 1'b0, 200, 5, 0);
        send("iso2", 0, 10, 1'b0, 110, 5, 0);

        // Saturation
        write_coeffs(256, 256, 256, 256);
        do_flush();
        send("satp0", 0, 511, 1'b0, 511, 5, 0);
        send("satp1", 0, 511, 1'b0, 511, 5, 0);
        send("satp2", 0, 511, 1'b0, 511, 5, 0);
        send("satp3", 0, 511, 1'b0, 511, 5, 0);
        do_flush();
        send("satn0", 0, -512, 1'b0, -512, 5, 0);
        send("satn1", 0, -512, 1'b0, -512, 5, 0);
        send("satn2", 0, -512, 1'b0, -512, 5, 0);
        send("satn3", 0, -512, 1'b0, -512, 5, 0);

        // Rounding
        write_coeffs(1, 0, 0, 0);
        send("rnd0", 0, 128, 1'b0, 1, 5, 0);
        send("rnd1", 0, 127, 1'b0, 0, 5, 0);
        send("rnd2", 0, -129, 1'b0, -1, 5, 0);

        // Coefficient write coinciding with accept applies; write in RUN ignored
        do_flush();
        @(negedge clk);
        ch_i         = 1'b0;
        data_i       = 10'sd40;
        in_valid_i   = 1'b1;
        coeff_we_i   = 1'b1;
        coeff_addr_i = 2'd0;
        coeff_i      = 10'sd128;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        coeff_i    = 10'sd0;
        @(posedge clk);
        #1;
        coeff_we_i = 1'b0;
        seen = 0;
        while (!out_valid_o && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("cw_accept_data", $signed(data_o), 20);
        @(posedge clk);
        send("cw_run_ignored", 0, 40, 1'b0, 20, 5, 0);

        // Backpressure, then bypass
        send("bp", 1, 80, 1'b0, 40, 5, 5);
        send("byp", 0, 300, 1'b1, 300, 1, 0);

        // Reset in the second RUN cycle
        write_coeffs(256, 0, 0, 0);
        @(negedge clk);
        ch_i       = 1'b0;
        data_i     = 10'sd50;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mrst_valid", out_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", in_ready_o, 0);
        chk("mrst_data", data_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("mrst_ready_after", in_ready_o, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        chk("mrst_no_output", seen, 0);
        send("mrst_imp0", 0, 100, 1'b0, 0, 5, 0);
        send("mrst_imp1", 0, 0, 1'b0, 0, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
